// File: rtl/axis_master_tx.sv
// axis_master_tx
//   Buffers user bytes in a small FIFO and emits them as AXI-Stream packets of
//   pkt_len beats, with tlast on the final beat and a one-cycle done pulse.
//
// Ports
//   m_axis_aclk, m_axis_arst   clock, synchronous active-high reset
//   start, pkt_len             packet request (pkt_len sampled with start)
//   data_in, data_in_valid     user payload into FIFO
//   data_in_ready              FIFO not full
//   m_axis_t{data,valid,last}  stream outputs, m_axis_tready downstream ready
//   busy                       packet in progress (SEND or DONE)
//   done                       one-cycle pulse after the last beat transfers
module axis_master_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_arst,
    input  logic              start,
    input  logic [3:0]        pkt_len,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;

    logic full, empty, push, pop, last_beat, accept_start;

    assign full         = (cnt_q == CW'(FIFO_DEPTH));
    assign empty        = (cnt_q == '0);
    assign push         = data_in_valid && !full;
    // tvalid is a function of state and occupancy only, so pop never loops
    // tready back into tvalid.
    assign pop          = m_axis_tvalid && m_axis_tready;
    assign last_beat    = (beat_cnt_q == (len_q - 4'd1));
    assign accept_start = start && (pkt_len != 4'd0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_arst) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_start)     state_d = SEND;
            SEND:    if (pop && last_beat) state_d = DONE;
            DONE:                          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        m_axis_tvalid = (state_q == SEND) && !empty;
        m_axis_tlast  = (state_q == SEND) && !empty && last_beat;
        m_axis_tdata  = mem_q[rd_ptr_q];
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        data_in_ready = !full;
    end

    // ---------------- FIFO and packet counters ----------------
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (state_q == IDLE && accept_start) begin
            len_d      = pkt_len;
            beat_cnt_d = 4'd0;
        end else if (pop) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
        end
    end

    // Storage is cleared on reset so tdata reads 0 until the first push.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_arst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
